// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates the single-port memory between the instruction-fetch path and the
// accumulator data path. Data wins contested cycles until it has taken
// STARVE_MAX consecutive contested grants. At that point, fetch is forced
// through. A registered return tag steers the one-cycle-late read data back
// to the port that issued the read.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and address
//   if_gnt              fetch granted this cycle (combinational)
//   if_rvalid/if_rdata  fetch read return, one cycle after the grant
//   d_req/d_we/d_addr/d_wdata  data request (store when d_we=1, load when 0)
//   d_gnt               data granted this cycle (combinational)
//   d_rvalid/d_rdata    load read return, one cycle after the grant
//   mem_en/mem_we/mem_addr/mem_wdata  memory drive for the granted access
//   mem_rdata           memory read data, valid the cycle after a read
//   fetch_stall_cnt     saturating count of cycles with fetch waiting
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    fetch_stall_cnt
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt, starve_cnt_nxt;
  tag_e       tag, tag_nxt;
  logic       fetch_forced;

  // Fetch has waited through STARVE_MAX contested data grants.
  assign fetch_forced = (starve_cnt == STARVE_LIM);

  // NOTE: every output of this block is given a default first, so that no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    starve_cnt_nxt = starve_cnt;
    tag_nxt        = TAG_NONE;

    // Grants are held off while reset is asserted, even though they are
    // combinational from the requests.
    if (rst_n) begin
      if (d_req && !(if_req && fetch_forced)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end

    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      tag_nxt   = d_we ? TAG_NONE : TAG_DATA;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      tag_nxt  = TAG_FETCH;
    end

    // Only a contested data grant advances the count. Any fetch grant, or a
    // cycle without a fetch request, restarts it.
    if (!if_req || if_gnt) begin
      starve_cnt_nxt = 4'd0;
    end else if (d_gnt) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      tag        <= TAG_NONE;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      tag        <= tag_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_stall_cnt <= 8'd0;
    end else if (if_req && !if_gnt && (fetch_stall_cnt != 8'hFF)) begin
      fetch_stall_cnt <= fetch_stall_cnt + 8'd1;
    end
  end

  // Read return: only the port named by the tag sees valid data. The other
  // port's data is held at zero.
  assign if_rvalid = (tag == TAG_FETCH);
  assign d_rvalid  = (tag == TAG_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (AW=8, DW=8, STARVE_MAX=3).
// A simple memory model answers the DUT's memory port. A separate reference
// model predicts the following from the request stream alone:
//   - grants
//   - memory drive
//   - read returns
//   - the fetch stall count
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int STARVE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       if_req, d_req, d_we;
  logic [7:0] if_addr, d_addr, d_wdata;
  logic       if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [7:0] if_rdata, d_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] fetch_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fetch_stall_cnt(fetch_stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Memory attached to the DUT. Outside a read return it drives random
  // garbage, so that any leak of mem_rdata onto an unselected port shows up.
  logic [7:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
    else                   mem_rdata <= 8'($urandom);
  end

  // Reference model. Inputs are the requests only; the DUT is never read.
  localparam int P_NONE = 0, P_FETCH = 1, P_DATA = 2;
  logic [7:0] ref_mem [256];
  int         contested  = 0;  // consecutive contested data grants
  int         stall      = 0;  // stalled fetch cycles, saturating at 255
  int         pend       = P_NONE;
  logic [7:0] pend_data  = 8'd0;
  logic       m_if_gnt   = 1'b0;
  logic       m_d_gnt    = 1'b0;

  always @(negedge clk) begin : cmp
    logic       e_i, e_d;
    logic [7:0] e_addr;
    if (!rst_n) begin
      check("reset_outputs",
            64'({if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata, fetch_stall_cnt}),
            64'd0);
      contested = 0;
      stall     = 0;
      pend      = P_NONE;
      m_if_gnt  = 1'b0;
      m_d_gnt   = 1'b0;
    end else begin
      e_d    = d_req && !(if_req && contested >= STARVE);
      e_i    = if_req && !e_d;
      e_addr = e_d ? d_addr : (e_i ? if_addr : 8'd0);
      check("if_gnt",    64'(if_gnt),    64'(e_i));
      check("d_gnt",     64'(d_gnt),     64'(e_d));
      check("mem_en",    64'(mem_en),    64'(e_i | e_d));
      check("mem_we",    64'(mem_we),    64'(e_d & d_we));
      check("mem_addr",  64'(mem_addr),  64'(e_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(e_d ? d_wdata : 8'd0));
      check("if_rvalid", 64'(if_rvalid), 64'(pend == P_FETCH));
      check("if_rdata",  64'(if_rdata),  64'(pend == P_FETCH ? pend_data : 8'd0));
      check("d_rvalid",  64'(d_rvalid),  64'(pend == P_DATA));
      check("d_rdata",   64'(d_rdata),   64'(pend == P_DATA ? pend_data : 8'd0));
      check("fetch_stall_cnt", 64'(fetch_stall_cnt), 64'(stall));

      if (if_req && !e_i && stall < 255) stall++;
      if (if_req && d_req && e_d) contested++;
      else if (!if_req || e_i)    contested = 0;

      pend = P_NONE;
      if (e_i) begin
        pend      = P_FETCH;
        pend_data = ref_mem[if_addr];
      end else if (e_d && !d_we) begin
        pend      = P_DATA;
        pend_data = ref_mem[d_addr];
      end else if (e_d) begin
        ref_mem[d_addr] = d_wdata;
      end
      m_if_gnt = e_i;
      m_d_gnt  = e_d;
    end
  end

  // Waits until just after the next edge, applies the inputs, then returns
  // at the following falling edge, where outputs are stable.
  task automatic drive(input logic ireq, input logic [7:0] iaddr,
                       input logic dreq, input logic dwe,
                       input logic [7:0] daddr, input logic [7:0] dwdata);
    @(posedge clk);
    #1;
    if_req  = ireq;
    if_addr = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_addr  = daddr;
    d_wdata = dwdata;
    @(negedge clk);
  endtask

  logic [7:0] pat_d, pat_i;
  logic       hold_i, hold_d;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 8'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'd0; d_wdata = 8'd0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[8'h05] = 8'hA3;
    ref_mem[8'h05] = 8'hA3;

    repeat (2) @(negedge clk);
    check("reset_stall_cnt", 64'(fetch_stall_cnt), 64'd0);
    check("reset_gnt_blocked", 64'({if_gnt, d_gnt}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fetch only.
    drive(1, 8'h05, 0, 0, 8'h00, 8'h00);
    check("fetch_gnt_lit", 64'({if_gnt, mem_en, mem_we}), 64'b110);
    check("fetch_addr_lit", 64'(mem_addr), 64'h05);
    drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
    check("fetch_rvalid_lit", 64'(if_rvalid), 64'd1);
    check("fetch_rdata_lit", 64'(if_rdata), 64'hA3);

    // Store, then load from the same address.
    drive(0, 8'h00, 1, 1, 8'h10, 8'h7E);
    check("store_we_lit", 64'({d_gnt, mem_we}), 64'b11);
    drive(0, 8'h00, 1, 0, 8'h10, 8'h00);
    check("store_no_rvalid_lit", 64'({d_rvalid, if_rvalid}), 64'd0);
    check("load_gnt_lit", 64'(d_gnt), 64'd1);
    drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
    check("load_rdata_lit", 64'({d_rvalid, d_rdata}), 64'h17E);

    // Contention: data gets three grants, then fetch is forced through.
    for (int c = 0; c < 8; c++) begin
      drive(1, 8'h20, 1, 0, 8'h30, 8'h00);
      pat_d[c] = d_gnt;
      pat_i[c] = if_gnt;
    end
    drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
    check("contend_d_pattern", 64'(pat_d), 64'h77);
    check("contend_i_pattern", 64'(pat_i), 64'h88);
    check("contend_stall_lit", 64'(fetch_stall_cnt), 64'd6);

    // Starvation clear: a cycle without fetch request restarts the count.
    for (int c = 0; c < 7; c++) begin
      drive(c != 2, 8'h21, 1, 0, 8'h31, 8'h00);
      pat_d[c] = d_gnt;
      pat_i[c] = if_gnt;
    end
    check("clear_d_pattern", 64'(pat_d[6:0]), 64'h3F);
    check("clear_i_pattern", 64'(pat_i[6:0]), 64'h40);

    // Reset while a fetch read is outstanding.
    drive(1, 8'h22, 0, 0, 8'h00, 8'h00);
    check("rstmid_gnt_lit", 64'(if_gnt), 64'd1);
    #2;
    rst_n = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    check("rstmid_no_rvalid", 64'(if_rvalid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 8'h05;
    @(negedge clk);
    check("rstmid_after_rvalid", 64'(if_rvalid), 64'd0);
    check("rstmid_after_cnt", 64'(fetch_stall_cnt), 64'd0);
    check("first_gnt_after_rst", 64'(d_gnt), 64'd1);

    // Random traffic. A request that was not granted is held with the same
    // address and data until it is granted.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      hold_i = if_req && !m_if_gnt;
      hold_d = d_req && !m_d_gnt;
      if (!hold_i) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 8'($urandom_range(0, 15));
      end
      if (!hold_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom);
        d_addr  = 8'($urandom_range(0, 15));
        d_wdata = 8'($urandom);
      end
      @(negedge clk);
    end

    // Saturation of the stall counter.
    for (int c = 0; c < 400; c++) drive(1, 8'h40, 1, 0, 8'h41, 8'h00);
    drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
    check("stall_saturated", 64'(fetch_stall_cnt), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port 8-bit data/instruction memory between the instruction-fetch path and the accumulator data path (load/store) of the 8-bit processor. Each requester uses a request/grant handshake. A starvation counter bounds how long data traffic can block fetch. One-cycle read latency is tracked so that read data returns to the port that issued the read.

## Interface
- AW, 8, memory address width
- DW, 8, memory data width
- STARVE_MAX, 3, consecutive contested data grants allowed before fetch is forced through (1..15)
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset: asynchronous, active-low
- if_req  in  1  fetch request
- if_addr  in  AW  fetch address; stable while if_req high and not granted
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid
- d_rdata  out  DW  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid the cycle after a read access
- fetch_stall_cnt  out  8  saturating count of cycles with if_req high and if_gnt low

## Operation
- At most one grant per cycle. if_gnt and d_gnt are never both 1.
- Arbitration:
  - only d_req high → grant data;
  - only if_req high → grant fetch;
  - both high → grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
- starve_cnt (4-bit, internal):
  - +1 on each cycle where both requests are high and data is granted;
  - cleared to 0 on any fetch grant, or any cycle with if_req low;
  - otherwise it holds its value;
  - never exceeds STARVE_MAX.
- Memory drive in the grant cycle:
  - mem_en=1; mem_addr = granted address;
  - data grant: mem_we = d_we, mem_wdata = d_wdata;
  - fetch grant: mem_we=0, mem_wdata=0.
- With no grant, mem_en, mem_we, mem_addr and mem_wdata are all 0.
- Read-return tag (registered): set to FETCH after a fetch grant, DATA after a data load grant, NONE otherwise (idle, or a store).
- Next cycle:
  - tag FETCH → if_rvalid=1;
  - tag DATA → d_rvalid=1;
  - the corresponding rdata = mem_rdata;
  - the non-selected rdata output and all rvalid outputs not selected are 0.
- Stores produce no rvalid.
- Back-to-back: a requester may hold req high across consecutive grants. Each grant is an independent access, and its rvalid follows exactly one cycle later.
- Requesters must hold address/data stable until gnt. The arbiter does not latch them.
- fetch_stall_cnt increments on each stalled fetch cycle, saturates at 255, and clears only on reset.

## Timing
- Grant latency: 0 cycles (combinational from req and registered starve_cnt).
- Read latency: rvalid/rdata in cycle N+1 for a grant in cycle N. Sustained throughput is 1 access/cycle.
- Worst-case fetch wait under continuous data traffic: STARVE_MAX cycles, granted in cycle STARVE_MAX+1.
- Reset values: if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, fetch_stall_cnt=0, starve_cnt=0, tag=NONE.
- While rst_n is low, grants are forced to 0 regardless of requests.
- Reset asserted mid-operation: a pending read return (tag set) is dropped and no rvalid appears after reset release.
- First grant is possible in the first rising edge cycle after rst_n deasserts.

## Test plan
- Fetch only: if_req=1, if_addr=0x05, memory[0x05]=0xA3 → if_gnt=1 in cycle 0, mem_en=1, mem_addr=0x05, mem_we=0; if_rvalid=1, if_rdata=0xA3 in cycle 1.
- Store then load: d_req/d_we=1, d_addr=0x10, d_wdata=0x7E, then d_we=0 at the same address → mem_we=1 in cycle 0 with no rvalid in cycle 1; the load grant follows, with d_rvalid=1, d_rdata=0x7E one cycle after it.
- Contention with STARVE_MAX=3: if_req and d_req both held high → data granted in cycles 0-2, fetch in cycle 3, data in cycles 4-6, fetch in cycle 7; fetch_stall_cnt=6 after cycle 7.
- Starvation clear: both requests high for 2 cycles, if_req low for 1 cycle, then both high again → starve_cnt restarts from 0 and data gets 3 more grants before fetch.
- Reset mid-read: fetch granted in cycle 0 and rst_n pulled low before edge 1 → all outputs 0, if_rvalid never asserts for that read, counters are 0 after release.
- Saturation: if_req=1 with d_req=1 and STARVE_MAX=15 for 300 cycles → fetch_stall_cnt stops at 255.
